// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the counter family.
//   - mode_t : 2-bit counting mode encoding used on the `mode` input.
//       MODE_UP     (00) : count up, wrap MODULO-1 -> 0
//       MODE_DOWN   (01) : count down, wrap 0 -> MODULO-1
//       MODE_BOUNCE (10) : ping-pong between 0 and MODULO-1
//       MODE_HOLD   (11) : keep value and direction
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage : counter_pkg

// File: rtl/mode_counter_bin2gray.sv
// ----------------------------------------------------------------------------
// bin2gray
//   Combinational binary-to-Gray converter (reflected binary code).
//   Ports:
//     bin  in  WIDTH : binary value
//     gray out WIDTH : bin ^ (bin >> 1)
// ----------------------------------------------------------------------------
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : bin2gray

// File: rtl/mode_counter.sv
// ----------------------------------------------------------------------------
// mode_counter
//   Parametrised synchronous counter with up / down / bounce / hold modes,
//   parallel load, count enable and a one-cycle terminal-count strobe.
//   All state (binary count, direction, tc) is registered; latency is one
//   cycle from sampled inputs to outputs.
//
//   Parameters:
//     WIDTH  : counter width in bits
//     MODULO : count range 0..MODULO-1, 1 <= MODULO <= 2**WIDTH
//
//   Ports:
//     clk      in  1     : clock, rising edge
//     rst      in  1     : synchronous active-high reset (q=0, dir=1, tc=0)
//     en       in  1     : count enable, one step per cycle
//     mode     in  2     : mode_t (00 up, 01 down, 10 bounce, 11 hold)
//     load     in  1     : parallel load strobe (priority over en)
//     load_val in  WIDTH : load value, clamped to MODULO-1
//     q        out WIDTH : count (Gray-coded in the Gray build)
//     dir      out 1     : current direction, 1 = up
//     tc       out 1     : terminal-count strobe, high with the wrapped or
//                          turned value
//
//   Build option:
//     MODE_COUNTER_GRAY_OUT_EN : when defined, q = bin ^ (bin >> 1) of the
//                                internal binary count; otherwise q is the
//                                plain binary count.
// ----------------------------------------------------------------------------
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int MODULO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    if ((MODULO < 1) || (longint'(MODULO) > (longint'(1) << WIDTH))) begin : g_bad_modulo
        $error("mode_counter: MODULO must satisfy 1 <= MODULO <= 2**WIDTH");
    end

    // Largest legal count and the bounce turnaround targets. For MODULO=1
    // the only legal value is 0, so both turnaround targets collapse to 0.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] TURN_TOP = (MODULO > 1) ? WIDTH'(MODULO - 2) : '0;
    localparam logic [WIDTH-1:0] TURN_BOT = (MODULO > 1) ? WIDTH'(1) : '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_bin;
    logic             dir_r;
    logic             tc_r;

    logic [WIDTH-1:0] q_nxt;
    logic             dir_nxt;
    logic             tc_nxt;

    mode_t            mode_s;

    assign mode_s = mode_t'(mode);

    // ------------------------------------------------------------------
    // Next-state: load has priority over counting. Increments only happen
    // below MAX_VAL and decrements only above 0, so the WIDTH-bit
    // arithmetic never overflows even when MODULO = 2**WIDTH.
    // ------------------------------------------------------------------
    always_comb begin
        q_nxt   = q_bin;
        dir_nxt = dir_r;
        tc_nxt  = 1'b0;

        if (load) begin
            q_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            case (mode_s)
                MODE_UP:   dir_nxt = 1'b1;
                MODE_DOWN: dir_nxt = 1'b0;
                default:   dir_nxt = dir_r;
            endcase
        end else if (en) begin
            case (mode_s)
                MODE_UP: begin
                    dir_nxt = 1'b1;
                    if (q_bin == MAX_VAL) begin
                        q_nxt  = '0;
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = q_bin + ONE;
                    end
                end

                MODE_DOWN: begin
                    dir_nxt = 1'b0;
                    if (q_bin == '0) begin
                        q_nxt  = MAX_VAL;
                        tc_nxt = 1'b1;
                    end else begin
                        q_nxt = q_bin - ONE;
                    end
                end

                MODE_BOUNCE: begin
                    // The end value is shown for one cycle, then the next
                    // step turns around and moves one away from the end.
                    if (dir_r) begin
                        if (q_bin == MAX_VAL) begin
                            q_nxt   = TURN_TOP;
                            dir_nxt = 1'b0;
                            tc_nxt  = 1'b1;
                        end else begin
                            q_nxt = q_bin + ONE;
                        end
                    end else begin
                        if (q_bin == '0) begin
                            q_nxt   = TURN_BOT;
                            dir_nxt = 1'b1;
                            tc_nxt  = 1'b1;
                        end else begin
                            q_nxt = q_bin - ONE;
                        end
                    end
                end

                default: begin
                    // MODE_HOLD: keep q and dir, tc stays low
                    q_nxt   = q_bin;
                    dir_nxt = dir_r;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_bin <= '0;
            dir_r <= 1'b1;
            tc_r  <= 1'b0;
        end else begin
            q_bin <= q_nxt;
            dir_r <= dir_nxt;
            tc_r  <= tc_nxt;
        end
    end

    assign dir = dir_r;
    assign tc  = tc_r;

    // ------------------------------------------------------------------
    // Output encoding
    // ------------------------------------------------------------------
`ifdef MODE_COUNTER_GRAY_OUT_EN
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (q_bin),
        .gray (q)
    );
`else
    assign q = q_bin;
`endif

endmodule : mode_counter
